// File: rtl/eth_crc_engine.sv
`default_nettype none
// -----------------------------------------------------------------------------
// eth_crc_engine : framed reflected CRC-32 generate/check, DATA_BYTES per clock
// Revision       : 1.0
// -----------------------------------------------------------------------------
module eth_crc_engine #(
    parameter int          DATA_BYTES = 4,
    parameter logic [31:0] POLY       = 32'hEDB88320,
    parameter logic [31:0] INIT       = 32'hFFFFFFFF,
    parameter logic [31:0] XOR_OUT    = 32'hFFFFFFFF,
    parameter logic [31:0] RESIDUE    = 32'hDEBB20E3
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic                      In_Valid,
    input  logic                      In_Sof,
    input  logic                      In_Eof,
    input  logic [DATA_BYTES-1:0]     In_Keep,
    input  logic [8*DATA_BYTES-1:0]   In_Data,
    input  logic                      Mode,
    output logic                      Crc_Valid,
    output logic [31:0]               Crc_Out,
    output logic                      Crc_Ok,
    output logic [15:0]               Byte_Count,
    output logic                      Busy,
    output logic                      Frame_Err
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [31:0]           crc_q, crc_d;
    logic [15:0]           count_q, count_d;
    logic                  mode_q, mode_d;
    logic                  crc_valid_q, crc_valid_d;
    logic [31:0]           crc_out_q, crc_out_d;
    logic                  crc_ok_q, crc_ok_d;
    logic [15:0]           byte_count_q, byte_count_d;
    logic                  frame_err_q, frame_err_d;

    logic                  word_fold;
    logic                  mode_eff;
    logic [DATA_BYTES-1:0] lane_en;
    logic [31:0]           crc_base;
    logic [31:0]           crc_fold;
    logic [4:0]            lanes;
    logic [15:0]           count_base;
    logic [16:0]           count_sum;
    logic [15:0]           count_fold;

    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            c = (c >> 1) ^ ((c[0] ^ b[i]) ? POLY : 32'h0);
        end
        return c;
    endfunction

    // A word is folded when it opens a frame or continues an open one; stray words are dropped.
    assign word_fold = In_Valid & (In_Sof | (state_q == ST_ACTIVE));
    assign mode_eff  = In_Sof ? Mode : mode_q;
    assign lane_en   = In_Eof ? In_Keep : {DATA_BYTES{1'b1}};
    assign crc_base  = In_Sof ? INIT : crc_q;

    // Byte-stage unroll; a disabled lane is bypassed, not fed as zero.
    always_comb begin
        crc_fold = crc_base;
        lanes    = 5'd0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            if (lane_en[i]) begin
                crc_fold = crc_byte(crc_fold, In_Data[8*i +: 8]);
                lanes    = lanes + 5'd1;
            end
        end
    end

    assign count_base = In_Sof ? 16'h0000 : count_q;
    assign count_sum  = {1'b0, count_base} + {12'b0, lanes};
    assign count_fold = count_sum[16] ? 16'hFFFF : count_sum[15:0];

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (word_fold) begin
            state_d = In_Eof ? ST_IDLE : ST_ACTIVE;
        end
    end

    always_comb begin
        Busy = (state_q == ST_ACTIVE);
    end

    always_comb begin
        crc_d        = crc_q;
        count_d      = count_q;
        mode_d       = mode_q;
        crc_valid_d  = 1'b0;
        crc_out_d    = crc_out_q;
        crc_ok_d     = crc_ok_q;
        byte_count_d = byte_count_q;
        frame_err_d  = 1'b0;
        if (In_Valid && (In_Sof == (state_q == ST_ACTIVE))) begin
            frame_err_d = 1'b1;
        end
        if (word_fold) begin
            crc_d   = crc_fold;
            count_d = count_fold;
            mode_d  = mode_eff;
            if (In_Eof) begin
                crc_valid_d  = 1'b1;
                crc_out_d    = crc_fold ^ XOR_OUT;
                crc_ok_d     = mode_eff & (crc_fold == RESIDUE);
                byte_count_d = count_fold;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            crc_q        <= INIT;
            count_q      <= 16'h0000;
            mode_q       <= 1'b0;
            crc_valid_q  <= 1'b0;
            crc_out_q    <= 32'h0;
            crc_ok_q     <= 1'b0;
            byte_count_q <= 16'h0000;
            frame_err_q  <= 1'b0;
        end else begin
            crc_q        <= crc_d;
            count_q      <= count_d;
            mode_q       <= mode_d;
            crc_valid_q  <= crc_valid_d;
            crc_out_q    <= crc_out_d;
            crc_ok_q     <= crc_ok_d;
            byte_count_q <= byte_count_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign Crc_Valid  = crc_valid_q;
    assign Crc_Out    = crc_out_q;
    assign Crc_Ok     = crc_ok_q;
    assign Byte_Count = byte_count_q;
    assign Frame_Err  = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_eth_crc_engine.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_eth_crc_engine : directed self-checking bench for eth_crc_engine
// Revision          : 1.0
// -----------------------------------------------------------------------------
module tb_eth_crc_engine;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        In_Valid, In_Sof, In_Eof, Mode;
    logic [3:0]  In_Keep;
    logic [31:0] In_Data;
    logic        Crc_Valid, Crc_Ok, Busy, Frame_Err;
    logic [31:0] Crc_Out;
    logic [15:0] Byte_Count;

    int checks = 0;
    int errors = 0;

    logic        sv[3], ss[3], se[3];
    logic [7:0]  sk[3];
    logic [63:0] sd[3];
    logic        s_valid[3], s_ok[3], s_busy[3], s_err[3];
    logic [31:0] s_out[3];
    logic [15:0] s_cnt[3];
    logic [7:0]  msg[9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

    always #5 Clk = ~Clk;

    eth_crc_engine #(.DATA_BYTES(4)) u_dut (
        .Clk(Clk), .Rst(Rst), .In_Valid(In_Valid), .In_Sof(In_Sof), .In_Eof(In_Eof),
        .In_Keep(In_Keep), .In_Data(In_Data), .Mode(Mode), .Crc_Valid(Crc_Valid),
        .Crc_Out(Crc_Out), .Crc_Ok(Crc_Ok), .Byte_Count(Byte_Count), .Busy(Busy),
        .Frame_Err(Frame_Err));

    eth_crc_engine #(.DATA_BYTES(1)) u_w1 (
        .Clk(Clk), .Rst(Rst), .In_Valid(sv[0]), .In_Sof(ss[0]), .In_Eof(se[0]),
        .In_Keep(sk[0][0:0]), .In_Data(sd[0][7:0]), .Mode(1'b0), .Crc_Valid(s_valid[0]),
        .Crc_Out(s_out[0]), .Crc_Ok(s_ok[0]), .Byte_Count(s_cnt[0]), .Busy(s_busy[0]),
        .Frame_Err(s_err[0]));

    eth_crc_engine #(.DATA_BYTES(2)) u_w2 (
        .Clk(Clk), .Rst(Rst), .In_Valid(sv[1]), .In_Sof(ss[1]), .In_Eof(se[1]),
        .In_Keep(sk[1][1:0]), .In_Data(sd[1][15:0]), .Mode(1'b0), .Crc_Valid(s_valid[1]),
        .Crc_Out(s_out[1]), .Crc_Ok(s_ok[1]), .Byte_Count(s_cnt[1]), .Busy(s_busy[1]),
        .Frame_Err(s_err[1]));

    eth_crc_engine #(.DATA_BYTES(8)) u_w8 (
        .Clk(Clk), .Rst(Rst), .In_Valid(sv[2]), .In_Sof(ss[2]), .In_Eof(se[2]),
        .In_Keep(sk[2]), .In_Data(sd[2]), .Mode(1'b0), .Crc_Valid(s_valid[2]),
        .Crc_Out(s_out[2]), .Crc_Ok(s_ok[2]), .Byte_Count(s_cnt[2]), .Busy(s_busy[2]),
        .Frame_Err(s_err[2]));

    // Drive one word for one clock, then return with outputs of that edge settled.
    task automatic send(input logic sof, input logic eof, input logic [3:0] keep, input logic [31:0] data);
        In_Valid = 1'b1; In_Sof = sof; In_Eof = eof; In_Keep = keep; In_Data = data;
        @(negedge Clk);
        In_Valid = 1'b0; In_Sof = 1'b0; In_Eof = 1'b0; In_Keep = 4'h0; In_Data = 32'h0;
    endtask

    task automatic idle;
        @(negedge Clk);
    endtask

    task automatic test_reset;
        Rst = 1'b1;
        repeat (2) @(negedge Clk);
        checks++; if (Crc_Valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", Crc_Valid); end
        checks++; if (Crc_Out !== 32'h0) begin errors++; $display("FAIL reset_out: got %h expected 00000000", Crc_Out); end
        checks++; if ({Crc_Ok, Busy, Frame_Err} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {Crc_Ok, Busy, Frame_Err}); end
        checks++; if (Byte_Count !== 16'h0) begin errors++; $display("FAIL reset_count: got %h expected 0000", Byte_Count); end
        Rst = 1'b0;
        idle();
    endtask

    task automatic test_generate;
        send(1'b1, 1'b0, 4'hF, 32'h34333231);
        checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL gen_busy: got %b expected 1", Busy); end
        send(1'b0, 1'b0, 4'hF, 32'h38373635);
        checks++; if (Crc_Valid !== 1'b0) begin errors++; $display("FAIL gen_early_valid: got %b expected 0", Crc_Valid); end
        send(1'b0, 1'b1, 4'h1, 32'h00000039);
        checks++; if (Crc_Valid !== 1'b1) begin errors++; $display("FAIL gen_valid: got %b expected 1", Crc_Valid); end
        checks++; if (Crc_Out !== 32'hCBF43926) begin errors++; $display("FAIL gen_crc: got %h expected cbf43926", Crc_Out); end
        checks++; if (Byte_Count !== 16'd9) begin errors++; $display("FAIL gen_count: got %0d expected 9", Byte_Count); end
        checks++; if ({Crc_Ok, Busy} !== 2'b00) begin errors++; $display("FAIL gen_ok_busy: got %b expected 00", {Crc_Ok, Busy}); end
        idle();
        checks++; if (Crc_Valid !== 1'b0) begin errors++; $display("FAIL gen_strobe_len: got %b expected 0", Crc_Valid); end
        checks++; if (Crc_Out !== 32'hCBF43926) begin errors++; $display("FAIL gen_hold: got %h expected cbf43926", Crc_Out); end
    endtask

    task automatic test_check;
        Mode = 1'b1;
        send(1'b1, 1'b0, 4'hF, 32'h34333231);
        Mode = 1'b0;
        send(1'b0, 1'b0, 4'hF, 32'h38373635);
        send(1'b0, 1'b0, 4'hF, 32'hF4392639);
        send(1'b0, 1'b1, 4'h1, 32'h000000CB);
        checks++; if ({Crc_Valid, Crc_Ok} !== 2'b11) begin errors++; $display("FAIL chk_good_ok: got %b expected 11", {Crc_Valid, Crc_Ok}); end
        checks++; if (Byte_Count !== 16'd13) begin errors++; $display("FAIL chk_count: got %0d expected 13", Byte_Count); end
        checks++; if (Crc_Out !== 32'h2144DF1C) begin errors++; $display("FAIL chk_residue: got %h expected 2144df1c", Crc_Out); end
        Mode = 1'b1;
        send(1'b1, 1'b0, 4'hF, 32'h34333231);
        Mode = 1'b0;
        send(1'b0, 1'b0, 4'hF, 32'h38373634);
        send(1'b0, 1'b0, 4'hF, 32'hF4392639);
        send(1'b0, 1'b1, 4'h1, 32'h000000CB);
        checks++; if ({Crc_Valid, Crc_Ok} !== 2'b10) begin errors++; $display("FAIL chk_bad_ok: got %b expected 10", {Crc_Valid, Crc_Ok}); end
        checks++; if (Byte_Count !== 16'd13) begin errors++; $display("FAIL chk_bad_count: got %0d expected 13", Byte_Count); end
    endtask

    task automatic test_single_word;
        send(1'b1, 1'b1, 4'h1, 32'h00000000);
        checks++; if (Crc_Out !== 32'hD202EF8D || Crc_Valid !== 1'b1) begin errors++; $display("FAIL single_crc: got %h/%b expected d202ef8d/1", Crc_Out, Crc_Valid); end
        checks++; if (Byte_Count !== 16'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", Byte_Count); end
        send(1'b1, 1'b1, 4'h0, 32'h00000000);
        checks++; if (Crc_Out !== 32'h00000000 || Crc_Valid !== 1'b1) begin errors++; $display("FAIL empty_crc: got %h/%b expected 00000000/1", Crc_Out, Crc_Valid); end
        checks++; if (Byte_Count !== 16'd0) begin errors++; $display("FAIL empty_count: got %0d expected 0", Byte_Count); end
    endtask

    task automatic test_abort;
        int nvalid = 0;
        send(1'b1, 1'b0, 4'hF, 32'h34333231);
        checks++; if (Frame_Err !== 1'b0) begin errors++; $display("FAIL abort_pre_err: got %b expected 0", Frame_Err); end
        send(1'b1, 1'b0, 4'hF, 32'h34333231);
        checks++; if ({Frame_Err, Crc_Valid} !== 2'b10) begin errors++; $display("FAIL abort_err: got %b expected 10", {Frame_Err, Crc_Valid}); end
        send(1'b0, 1'b0, 4'hF, 32'h38373635);
        checks++; if ({Frame_Err, Crc_Valid} !== 2'b00) begin errors++; $display("FAIL abort_err_len: got %b expected 00", {Frame_Err, Crc_Valid}); end
        send(1'b0, 1'b1, 4'h1, 32'h00000039);
        if (Crc_Valid === 1'b1) nvalid++;
        checks++; if (Crc_Out !== 32'hCBF43926) begin errors++; $display("FAIL abort_crc: got %h expected cbf43926", Crc_Out); end
        idle();
        if (Crc_Valid === 1'b1) nvalid++;
        checks++; if (nvalid != 1) begin errors++; $display("FAIL abort_valid_count: got %0d expected 1", nvalid); end
        send(1'b0, 1'b0, 4'hF, 32'h12345678);
        checks++; if ({Frame_Err, Busy, Crc_Valid} !== 3'b100) begin errors++; $display("FAIL stray_err: got %b expected 100", {Frame_Err, Busy, Crc_Valid}); end
        idle();
        checks++; if ({Frame_Err, Busy} !== 2'b00) begin errors++; $display("FAIL stray_after: got %b expected 00", {Frame_Err, Busy}); end
    endtask

    task automatic test_reset_mid_frame;
        send(1'b1, 1'b0, 4'hF, 32'h34333231);
        Rst = 1'b1;
        idle();
        Rst = 1'b0;
        checks++; if ({Crc_Valid, Crc_Ok, Busy, Frame_Err} !== 4'b0000) begin errors++; $display("FAIL rst_mid_flags: got %b expected 0000", {Crc_Valid, Crc_Ok, Busy, Frame_Err}); end
        checks++; if (Crc_Out !== 32'h0 || Byte_Count !== 16'h0) begin errors++; $display("FAIL rst_mid_data: got %h/%h expected 0/0", Crc_Out, Byte_Count); end
        idle();
        checks++; if (Crc_Valid !== 1'b0) begin errors++; $display("FAIL rst_mid_no_valid: got %b expected 0", Crc_Valid); end
        send(1'b1, 1'b0, 4'hF, 32'h34333231);
        send(1'b0, 1'b0, 4'hF, 32'h38373635);
        send(1'b0, 1'b1, 4'h1, 32'h00000039);
        checks++; if (Crc_Out !== 32'hCBF43926 || Crc_Valid !== 1'b1) begin errors++; $display("FAIL rst_mid_clean: got %h/%b expected cbf43926/1", Crc_Out, Crc_Valid); end
    endtask

    task automatic test_back_to_back;
        send(1'b1, 1'b1, 4'h1, 32'h00000000);
        checks++; if (Crc_Out !== 32'hD202EF8D || Crc_Valid !== 1'b1) begin errors++; $display("FAIL b2b_first: got %h/%b expected d202ef8d/1", Crc_Out, Crc_Valid); end
        send(1'b1, 1'b1, 4'h1, 32'h00000031);
        checks++; if (Crc_Out !== 32'h83DCEFB7 || Crc_Valid !== 1'b1) begin errors++; $display("FAIL b2b_second: got %h/%b expected 83dcefb7/1", Crc_Out, Crc_Valid); end
        checks++; if (Frame_Err !== 1'b0) begin errors++; $display("FAIL b2b_err: got %b expected 0", Frame_Err); end
        idle();
    endtask

    task automatic test_width_sweep;
        int ptr[3]  = '{0, 0, 0};
        int seen[3] = '{0, 0, 0};
        int w[3]    = '{1, 2, 8};
        for (int c = 0; c < 120; c++) begin
            for (int k = 0; k < 3; k++) begin
                sv[k] = 1'b0; ss[k] = 1'b0; se[k] = 1'b0; sk[k] = 8'h0; sd[k] = 64'h0;
                if (ptr[k] < 9 && $urandom_range(0, 2) != 0) begin
                    sv[k] = 1'b1;
                    ss[k] = (ptr[k] == 0);
                    se[k] = (ptr[k] + w[k] >= 9);
                    for (int j = 0; j < w[k]; j++) begin
                        if (ptr[k] + j < 9) begin
                            sd[k][8*j +: 8] = msg[ptr[k] + j];
                            sk[k][j] = 1'b1;
                        end
                    end
                    ptr[k] = ptr[k] + w[k];
                end
            end
            @(negedge Clk);
            for (int k = 0; k < 3; k++) begin
                if (s_valid[k] === 1'b1) begin
                    seen[k]++;
                    checks++; if (s_out[k] !== 32'hCBF43926 || s_cnt[k] !== 16'd9) begin errors++; $display("FAIL sweep_crc_w%0d: got %h/%0d expected cbf43926/9", w[k], s_out[k], s_cnt[k]); end
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            sv[k] = 1'b0;
            checks++; if (seen[k] != 1) begin errors++; $display("FAIL sweep_valid_w%0d: got %0d strobes expected 1", w[k], seen[k]); end
        end
    endtask

    initial begin
        Rst = 1'b1; In_Valid = 1'b0; In_Sof = 1'b0; In_Eof = 1'b0; In_Keep = 4'h0;
        In_Data = 32'h0; Mode = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sv[k] = 1'b0; ss[k] = 1'b0; se[k] = 1'b0; sk[k] = 8'h0; sd[k] = 64'h0;
        end
        test_reset();
        test_generate();
        test_check();
        test_single_word();
        test_abort();
        test_reset_mid_frame();
        test_back_to_back();
        test_width_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/eth_crc_engine.md
Name: eth_crc_engine

Overview:
Parametrised CRC-32 engine that processes DATA_BYTES bytes per clock with framing (start/end of frame) and byte enables on the final word. It supports two modes: generate (emit the FCS for a payload) and check (compare the residue after payload+FCS). It serves both the eth_tx FCS append path and the eth_rx FCS check path, including wide datapaths beyond 8 bits.

Parameters:
DATA_BYTES, 4, bytes processed per cycle; legal values 1, 2, 4, 8.
POLY, 32'hEDB88320, reflected polynomial; the register shifts right, LSB first.
INIT, 32'hFFFFFFFF, register value loaded at start of frame.
XOR_OUT, 32'hFFFFFFFF, post-complement applied to Crc_Out.
RESIDUE, 32'hDEBB20E3, raw (un-complemented) register value expected after a good payload+FCS.

Ports:
Clk  in  1  clock
Rst  in  1  synchronous active-high reset
In_Valid  in  1  input word valid this cycle
In_Sof  in  1  first word of frame; qualified by In_Valid
In_Eof  in  1  last word of frame; qualified by In_Valid
In_Keep  in  DATA_BYTES  byte-lane enables, honoured only on the Eof word
In_Data  in  8*DATA_BYTES  lane 0 = bits [7:0] = first byte on the wire
Mode  in  1  0 = generate, 1 = check; sampled on the Sof word
Crc_Valid  out  1  one-cycle result strobe
Crc_Out  out  32  final register ^ XOR_OUT
Crc_Ok  out  1  check-mode pass flag
Byte_Count  out  16  bytes folded into the CRC for this frame
Busy  out  1  high while a frame is open
Frame_Err  out  1  one-cycle strobe on a protocol violation

Behaviour:
- Reset (Rst high at a Clk edge):
  - internal register = INIT; state = IDLE.
  - all outputs 0.
  - Any open frame is discarded and no Crc_Valid is produced for it.
- States: IDLE, ACTIVE.
  - IDLE, accepted word with Sof=1:
    - load INIT, fold the word, latch Mode, Byte_Count = lanes folded.
    - go to ACTIVE, or stay IDLE if Eof=1 on the same word.
  - IDLE, accepted word with Sof=0: word dropped; Frame_Err pulses the next cycle.
  - ACTIVE, accepted word with Sof=0: fold the word; on Eof=1 go to IDLE.
  - ACTIVE, accepted word with Sof=1 (abort and restart):
    - the current frame is discarded without a Crc_Valid; Frame_Err pulses.
    - the register is reloaded with INIT and the new word folded as a fresh frame.
  - In_Valid=0: no state change in any state; the register holds.
- Folding:
  - Lanes are folded in ascending order (lane 0 first), each byte LSB first into the reflected LFSR.
  - Non-Eof words: all lanes folded; In_Keep ignored.
  - Eof word: only lanes with In_Keep[i]=1 are folded, still in ascending order. Keep=0 lanes are skipped, not zero-fed.
  - Eof with In_Keep all zero: no bytes folded on that word.
  - Implementation is a combinational unroll of DATA_BYTES byte stages with a per-lane bypass mux, then one register stage.
- Byte_Count: increments by the number of lanes folded; saturates at 16'hFFFF.
- Results:
  - Crc_Valid is asserted exactly one cycle after the Eof word is accepted.
  - Crc_Out = register ^ XOR_OUT; it includes the Eof word's bytes.
  - Crc_Ok = (raw register == RESIDUE) when latched Mode=1; always 0 in generate mode.
  - Crc_Out, Crc_Ok and Byte_Count hold until the next Crc_Valid or Rst.
- Busy: 1 in ACTIVE; 0 in IDLE, including the Crc_Valid cycle.
- Back-to-back frames:
  - The Eof word may be followed immediately by the next Sof word with no bubble.
  - A Sof+Eof word in the cycle after an Eof yields Crc_Valid on two consecutive cycles.
- Mode changes mid-frame are ignored; only the Sof sample applies.

Test Plan:
1. DATA_BYTES=4, generate, ASCII "123456789":
   - Stimulus: words "1234" (Sof), "5678", "9" (Eof, Keep=0001).
   - Required: one cycle after the Eof word, Crc_Valid=1, Crc_Out=32'hCBF43926, Byte_Count=9, Crc_Ok=0.
2. DATA_BYTES=4, check:
   - Stimulus: "123456789" followed by FCS bytes 26 39 F4 CB, packed as words "1234","5678","9",0x26,0x39,0xF4 and final word 0xCB (Keep=0001).
   - Required: Crc_Ok=1, Byte_Count=13.
   - Repeat with bit 0 of byte '5' flipped: Crc_Ok=0.
3. Single word 0x00 with Sof=Eof=1 and Keep=0001 -> Crc_Out=32'hD202EF8D, Byte_Count=1. Same word with Keep=0000 -> Crc_Out=32'h00000000, Byte_Count=0.
4. Abort and protocol errors:
   - Sof "1234", then Sof "1234", "5678", "9"(Eof) -> exactly one Crc_Valid with 32'hCBF43926; Frame_Err pulses once.
   - Valid word without Sof while IDLE -> Frame_Err pulse, no state change.
5. Reset mid-frame: Rst after "1234" -> no Crc_Valid, all outputs 0; a following clean "123456789" frame yields 32'hCBF43926.
6. Back-to-back frames plus gaps:
   - Two consecutive Sof+Eof single-byte frames 0x00 and 0x31 -> Crc_Valid on two consecutive cycles with 32'hD202EF8D then 32'h83DCEFB7.
   - Parameter sweep DATA_BYTES=1,2,8 on test 1 with random In_Valid gaps -> same CRC.
